// File: rtl/framing_pkg.sv
// Shared constants and types for the serial framing / deframing pair.
// Both ends take their delimiter, preamble rules and state encoding from here.
package framing_pkg;

    // Start-of-frame delimiter, transmitted bit 0 first.
    localparam logic [15:0] SFD_DEFAULT     = 16'hF398;

    // Consecutive alternating bits needed before the delimiter is searched for.
    localparam int          PRE_MIN_DEFAULT = 16;

    // Longest delimiter search, in bits, before the attempt is abandoned.
    localparam int          SFD_TMO_DEFAULT = 80;

    // Output byte FIFO depth (power of two, at least 2).
    localparam int          FIFO_D_DEFAULT  = 4;

    // Receiver state: look for preamble, look for delimiter, collect bytes.
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Bits needed to hold a counter that runs from 0 up to max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: the oldest entry is always presented on o_head.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module byte_fifo
    import framing_pkg::*;
#(
    parameter int DEPTH = FIFO_D_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_wr_en;
    logic        w_rd_en;

    // Equal pointers mean empty; same index with opposite wrap bit means full.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so push-while-full is legal
    // when it coincides with a pop (the written slot is the one being read).
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // The head is forced to zero when nothing is stored.
    assign o_head = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

    // Advance read and write pointers; wrap-around is plain modulo arithmetic.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Store an accepted byte at the write slot.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; the
        // pointers define what is valid and o_head is masked while empty.
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/deframing.sv
// Serial deframer: finds an alternating preamble, locks onto the
// start-of-frame delimiter, then packs payload bits LSB-first into bytes
// that are handed to a small show-ahead FIFO.
module deframing
    import framing_pkg::*;
#(
    parameter logic [15:0] SFD     = SFD_DEFAULT,
    parameter int          PRE_MIN = PRE_MIN_DEFAULT,
    parameter int          SFD_TMO = SFD_TMO_DEFAULT,
    parameter int          FIFO_D  = FIFO_D_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_in_valid,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       in_frame,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int ALT_W  = cnt_width(PRE_MIN);
    localparam int SCNT_W = cnt_width(SFD_TMO + 1);

    localparam logic [ALT_W-1:0]  ALT_MAX  = ALT_W'(PRE_MIN);
    localparam logic [ALT_W-1:0]  ALT_ONE  = ALT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_TMO = SCNT_W'(SFD_TMO);
    localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);

    // Registered state
    state_t            r_state;
    logic [ALT_W-1:0]  r_alt_cnt;
    logic              r_prev_bit;
    logic [15:0]       r_window;
    logic [SCNT_W-1:0] r_sync_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_byte;
    logic              r_frame_done;
    logic              r_frame_err;

    // Next-state values and per-cycle controls
    state_t            w_state_nxt;
    logic [ALT_W-1:0]  w_alt_nxt;
    logic              w_prev_nxt;
    logic [15:0]       w_window_nxt;
    logic [SCNT_W-1:0] w_sync_nxt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        w_byte_nxt;
    logic              w_push;
    logic              w_err_fsm;
    logic              w_done_fsm;

    logic [15:0]       w_window_shift;
    logic [7:0]        w_byte_shift;

    // FIFO handshake
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_overflow;
    logic              w_err_due;

    // New bit enters at the top; after 16 bits bit 0 holds the oldest one.
    assign w_window_shift = {data_in, r_window[15:1]};
    assign w_byte_shift   = {data_in, r_byte[7:1]};

    // Hold the current state; everything else follows from next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_state_nxt;
    end

    // Next-state and datapath decisions for the hunt / sync / payload flow.
    always_comb begin
        // NOTE: every output of this block gets a value before the case
        // statement, so no path can leave one unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_alt_nxt    = r_alt_cnt;
        w_prev_nxt   = r_prev_bit;
        w_window_nxt = r_window;
        w_sync_nxt   = r_sync_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_byte_nxt   = r_byte;
        w_push       = 1'b0;
        w_err_fsm    = 1'b0;
        w_done_fsm   = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (!data_in_valid) begin
                    // Line idle: forget any partial preamble.
                    w_alt_nxt    = '0;
                    w_prev_nxt   = 1'b0;
                    w_window_nxt = '0;
                    w_sync_nxt   = '0;
                end else begin
                    w_prev_nxt = data_in;
                    // A count of zero means no previous bit to compare with.
                    if ((r_alt_cnt != '0) && (data_in != r_prev_bit))
                        w_alt_nxt = (r_alt_cnt == ALT_MAX) ? r_alt_cnt
                                                           : r_alt_cnt + ALT_ONE;
                    else
                        w_alt_nxt = ALT_ONE;

                    if (w_alt_nxt == ALT_MAX) begin
                        w_state_nxt  = ST_SYNC;
                        w_window_nxt = '0;
                        w_sync_nxt   = '0;
                    end
                end
            end

            ST_SYNC: begin
                if (!data_in_valid) begin
                    w_state_nxt  = ST_HUNT;
                    w_alt_nxt    = '0;
                    w_prev_nxt   = 1'b0;
                    w_window_nxt = '0;
                    w_sync_nxt   = '0;
                end else begin
                    w_window_nxt = w_window_shift;
                    w_sync_nxt   = r_sync_cnt + SCNT_ONE;
                    // The bit completing the delimiter counts toward the
                    // search budget, and a match on the last allowed bit wins.
                    if (w_window_shift == SFD) begin
                        w_state_nxt = ST_PAYLOAD;
                        w_bit_nxt   = '0;
                        w_byte_nxt  = '0;
                    end else if (w_sync_nxt > SCNT_TMO) begin
                        w_err_fsm    = 1'b1;
                        w_state_nxt  = ST_HUNT;
                        w_alt_nxt    = '0;
                        w_prev_nxt   = 1'b0;
                        w_window_nxt = '0;
                        w_sync_nxt   = '0;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!data_in_valid) begin
                    // End of frame is clean only on a byte boundary.
                    if (r_bit_cnt == 3'd0) w_done_fsm = 1'b1;
                    else                   w_err_fsm  = 1'b1;
                    w_state_nxt  = ST_HUNT;
                    w_alt_nxt    = '0;
                    w_prev_nxt   = 1'b0;
                    w_window_nxt = '0;
                    w_sync_nxt   = '0;
                    w_bit_nxt    = '0;
                    w_byte_nxt   = '0;
                end else begin
                    w_byte_nxt = w_byte_shift;
                    w_bit_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_push = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Register the preamble, delimiter and byte-assembly datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alt_cnt  <= '0;
            r_prev_bit <= 1'b0;
            r_window   <= '0;
            r_sync_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
        end else begin
            r_alt_cnt  <= w_alt_nxt;
            r_prev_bit <= w_prev_nxt;
            r_window   <= w_window_nxt;
            r_sync_cnt <= w_sync_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_byte     <= w_byte_nxt;
        end
    end

    // A byte arriving at a full FIFO with no pop in the same cycle is lost.
    assign w_pop      = data_out_ready && !w_fifo_empty;
    assign w_overflow = w_push && w_fifo_full && !w_pop;
    assign w_err_due  = w_err_fsm || w_overflow;

    // Status pulses are registered; an error suppresses a coincident done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err  <= w_err_due;
            r_frame_done <= w_done_fsm && !w_err_due;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_D)
    ) u_byte_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_byte_shift),
        .i_pop       (w_pop),
        .o_head      (data_out),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign data_out_valid = !w_fifo_empty;
    assign in_frame       = (r_state == ST_PAYLOAD);
    assign frame_done     = r_frame_done;
    assign frame_err      = r_frame_err;

endmodule

// File: doc/deframing.md
DEFRAMING -- requirements
Module: deframing

Interface
REQ-001 Parameter: SFD, 16'hF398, start-of-frame delimiter, received bit 0 first.
REQ-002 Parameter: PRE_MIN, 16, minimum consecutive alternating bits before SFD search.
REQ-003 Parameter: SFD_TMO, 80, maximum bits spent searching for SFD.
REQ-004 Parameter: FIFO_D, 4, output byte FIFO depth (power of 2).
REQ-005 Port: clk  in  1  single clock, all logic on the rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: data_in  in  1  serial line bit, from the framing transmitter.
REQ-008 Port: data_in_valid  in  1  data_in qualifier, high for the whole frame.
REQ-009 Port: data_out  out  8  head byte of the output FIFO.
REQ-010 Port: data_out_valid  out  1  FIFO not empty.
REQ-011 Port: data_out_ready  in  1  consumer accepts data_out this cycle.
REQ-012 Port: in_frame  out  1  level, high while in PAYLOAD.
REQ-013 Port: frame_done  out  1  one-cycle pulse, clean end of frame.
REQ-014 Port: frame_err  out  1  one-cycle pulse: SFD timeout, partial byte or FIFO overflow.

Function
REQ-015 FSM states: HUNT, SYNC, PAYLOAD; a bit is consumed only on cycles with data_in_valid=1.
REQ-016 HUNT: alternation counter (saturating at PRE_MIN) increments when data_in differs from the previous valid bit and reloads to 1 otherwise. Enter SYNC when the count reaches PRE_MIN.
REQ-017 SYNC: 16-bit window shifts right with the new bit entering at [15]; window==SFD enters PAYLOAD on the following edge. The match bit is inclusive.
REQ-018 SYNC: bit counter exceeds SFD_TMO without a match -> frame_err pulse and return to HUNT.
REQ-019 PAYLOAD: 3-bit counter, byte assembled LSB-first (shift right, new bit into [7]). The 8th bit's edge pushes the byte and the counter wraps to 0.
REQ-020 data_in_valid=0 in HUNT or SYNC: return to HUNT and clear counters and window, with no error.
REQ-021 data_in_valid=0 in PAYLOAD with bit counter 0: frame_done pulse next cycle, go to HUNT.
REQ-022 data_in_valid=0 in PAYLOAD with bit counter !=0: discard the partial byte, frame_err pulse, go to HUNT, no frame_done.
REQ-023 Latency: a pushed byte is visible on data_out with data_out_valid=1 on the cycle after the edge that sampled its 8th bit (show-ahead FIFO).
REQ-024 Pop happens when data_out_valid && data_out_ready. Push and pop in the same cycle are both honoured at any occupancy, including full.
REQ-025 Push when full without a same-cycle pop: byte dropped, frame_err pulse, FIFO contents unchanged, FSM continues.
REQ-026 FIFO pointers carry log2(FIFO_D)+1 bits. Full/empty come from MSB inequality/equality, and wrap-around is natural modulo.
REQ-027 frame_err and frame_done are registered and never asserted together; if both are due, frame_err wins.
REQ-028 The FIFO is not flushed at end of frame; bytes drain independently of the FSM.

Reset
REQ-029 rst=1 asynchronously forces: state HUNT, all counters/window/pointers 0, data_out 8'h00, data_out_valid 0, in_frame 0, frame_done 0, frame_err 0.
REQ-030 rst asserted mid-frame discards the FIFO contents and the partial byte. After release, sync needs a fresh preamble.

Structure
REQ-031 Shared package framing_pkg holds the SFD and preamble constants, the FSM state typedef and PRE_MIN/SFD_TMO defaults, shared with framing.
REQ-032 One sub-module: byte_fifo (parameterised depth, show-ahead, push/pop/full/empty), instanced once.

Verification
REQ-033 Stream of 64 preamble bits (0,1 alternating), SFD, bytes 8'h5A and 8'hC3, then valid low -> data_out 5A then C3, frame_done once, frame_err never.
REQ-034 Preamble of 8 bits only, then SFD -> stays in HUNT/SYNC, no bytes, in_frame 0.
REQ-035 Preamble followed by 100 bits of 0 -> frame_err pulse once, state HUNT, no bytes.
REQ-036 Valid frame, with valid dropped after 5 bits of the third byte -> two bytes out, frame_err pulse, no frame_done.
REQ-037 data_out_ready=0 with 6 bytes sent -> 4 bytes held, 2 frame_err pulses. Release ready -> the first 4 bytes drain in order.
REQ-038 rst pulse after 3 payload bytes -> all outputs 0 immediately. The next full frame decodes correctly.
